clock_display_scan: RTL and testbench

CLOCK_DISPLAY_SCAN -- requirements
Module: clock_display_scan

---
 rtl/clock_display_scan.sv | 142 ++++++++++++++
 tb/tb_clock_display_scan.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/clock_display_scan.sv
// Multiplexed 4-digit 7-segment scanner for an alarm clock.
// Inputs are captured once per frame; the alarm LED makes the whole display blink.
module clock_display_scan #(
  parameter int SCAN_DIV  = 4,
  parameter int BLINK_DIV = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cnt3,
  input  logic [3:0] cnt2,
  input  logic [3:0] cnt1,
  input  logic [3:0] cnt0,
  input  logic       led_on,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX   = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b0111111;
    endcase
  endfunction

  logic [PW-1:0]      pre_q, pre_d;
  logic [1:0]         idx_q, idx_d;
  logic [3:0][3:0]    sh_q, sh_d;
  logic               sh_led_q, sh_led_d;
  logic [BW-1:0]      blink_cnt_q, blink_cnt_d;
  logic               visible_q, visible_d;
  logic [3:0]         an_q, an_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;
  logic               frame_tick_q, frame_tick_d;
  logic               pre_wrap_s;
  logic               frame_wrap_s;
  logic [3:0]         digit_s;

  // Next-state for scan counters, shadow capture, blink phase and output decode.
  always_comb begin
    pre_wrap_s   = (pre_q == PRE_MAX);
    frame_wrap_s = pre_wrap_s && (idx_q == 2'd3);

    if (pre_wrap_s) begin
      pre_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      pre_d = pre_q + PW'(1);
      idx_d = idx_q;
    end

    if (frame_wrap_s) begin
      sh_d     = {cnt3, cnt2, cnt1, cnt0};
      sh_led_d = led_on;
    end else begin
      sh_d     = sh_q;
      sh_led_d = sh_led_q;
    end

    // A fresh alarm match restarts the blink with a full visible half-period.
    if (!sh_led_d || !sh_led_q) begin
      blink_cnt_d = '0;
      visible_d   = 1'b1;
    end else if (blink_cnt_q == BLINK_MAX) begin
      blink_cnt_d = '0;
      visible_d   = ~visible_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BW'(1);
      visible_d   = visible_q;
    end

    digit_s      = sh_d[idx_d];
    frame_tick_d = frame_wrap_s;

    if (!visible_d) begin
      an_d  = 4'b1111;
      seg_d = 7'b1111111;
      dp_d  = 1'b1;
    end else begin
      an_d = ~(4'b0001 << idx_d);
      if ((idx_d == 2'd3) && (digit_s == 4'd0)) begin
        seg_d = 7'b1111111;
      end else begin
        seg_d = seg_decode(digit_s);
      end
      if (idx_d == 2'd2) begin
        dp_d = 1'b0;
      end else begin
        dp_d = 1'b1;
      end
    end
  end

  // State and registered outputs; reset parks at the frame-wrap point.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q        <= PRE_MAX;
      idx_q        <= 2'd3;
      sh_q         <= '0;
      sh_led_q     <= 1'b0;
      blink_cnt_q  <= '0;
      visible_q    <= 1'b1;
      an_q         <= 4'b1111;
      seg_q        <= 7'b1111111;
      dp_q         <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      sh_q         <= sh_d;
      sh_led_q     <= sh_led_d;
      blink_cnt_q  <= blink_cnt_d;
      visible_q    <= visible_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_clock_display_scan.sv
// Bench for clock_display_scan: frame-arithmetic reference model checked every cycle,
// plus directed literal checks and a randomized soak.
module tb_clock_display_scan;

  localparam int SD = 4;
  localparam int BD = 32;
  localparam int FR = 4 * SD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] cnt3 = 4'd0, cnt2 = 4'd0, cnt1 = 4'd0, cnt0 = 4'd0;
  logic       led_on = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;

  int vecs = 0;
  int errs = 0;

  clock_display_scan #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst(rst),
    .cnt3(cnt3), .cnt2(cnt2), .cnt1(cnt1), .cnt0(cnt0),
    .led_on(led_on),
    .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: t counts cycles since reset release; frame/digit/blink follow from arithmetic.
  int         t = 0;
  logic [3:0] snap [4];
  logic       snap_led = 1'b0;
  int         led_start = 0;

  always begin
    int pos, digit;
    logic blank;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_dp, e_ft;
    @(posedge clk);
    if (rst) begin
      t = 0;
      for (int i = 0; i < 4; i++) snap[i] = 4'd0;
      snap_led = 1'b0;
    end else begin
      t++;
      if ((t - 1) % FR == 0) begin
        if (led_on && !snap_led) led_start = t;
        snap_led = led_on;
        snap[0] = cnt0; snap[1] = cnt1; snap[2] = cnt2; snap[3] = cnt3;
      end
    end
    if (t == 0) begin
      e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1; e_ft = 1'b0;
    end else begin
      pos   = (t - 1) % FR;
      digit = pos / SD;
      e_ft  = (pos == 0);
      blank = snap_led && ((((t - led_start) / BD) % 2) == 1);
      if (blank) begin
        e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1;
      end else begin
        e_an  = 4'b1111;
        e_an[digit] = 1'b0;
        e_seg = (digit == 3 && snap[3] == 4'd0) ? 7'b1111111 : seg_of(snap[digit]);
        e_dp  = (digit == 2) ? 1'b0 : 1'b1;
      end
    end
    #1;
    chk("outputs{an,seg,dp,ft}", {an, seg, dp, frame_tick}, {e_an, e_seg, e_dp, e_ft});
  end

  initial begin
    int guard;
    repeat (3) @(negedge clk);
    chk("rst_an", an, 4'b1111);
    chk("rst_seg", seg, 7'b1111111);
    chk("rst_ft", frame_tick, 1'b0);

    cnt3 = 4'd1; cnt2 = 4'd2; cnt1 = 4'd3; cnt0 = 4'd4; rst = 1'b0;
    @(negedge clk);                        // cycle 1
    chk("c1_ft", frame_tick, 1'b1);
    chk("c1_an", an, 4'b1110);
    chk("c1_seg", seg, 7'b0011001);
    repeat (4) @(negedge clk);             // cycle 5
    chk("c5_an", an, 4'b1101);
    chk("c5_seg", seg, 7'b0110000);
    chk("c5_ft", frame_tick, 1'b0);
    cnt0 = 4'd9;
    repeat (4) @(negedge clk);             // cycle 9
    chk("c9_an", an, 4'b1011);
    chk("c9_seg", seg, 7'b0100100);
    chk("c9_dp", dp, 1'b0);
    repeat (4) @(negedge clk);             // cycle 13
    chk("c13_an", an, 4'b0111);
    chk("c13_seg", seg, 7'b1111001);
    repeat (4) @(negedge clk);             // cycle 17
    chk("c17_ft", frame_tick, 1'b1);
    chk("c17_seg", seg, 7'b0010000);

    cnt3 = 4'd0; cnt1 = 4'd12;
    repeat (20) @(negedge clk);            // cycle 37: digit 1 of next frame
    chk("dash_seg", seg, 7'b0111111);
    repeat (8) @(negedge clk);             // cycle 45: digit 3
    chk("blank3_an", an, 4'b0111);
    chk("blank3_seg", seg, 7'b1111111);

    led_on = 1'b1;
    repeat (4) @(negedge clk);             // cycle 49: wrap, visible
    chk("blink_vis_an", an, 4'b1110);
    repeat (32) @(negedge clk);            // cycle 81: blank phase starts
    chk("blink_off_an", an, 4'b1111);
    chk("blink_off_ft", frame_tick, 1'b1);
    repeat (32) @(negedge clk);            // cycle 113: visible again
    chk("blink_on2_an", an, 4'b1110);

    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cnt0 = 4'($urandom_range(0, 15));
      cnt2 = 4'($urandom_range(0, 15));
    end
    led_on = 1'b0;
    repeat (40) @(negedge clk);

    // Reset pulse during the digit-2 dwell.
    guard = 0;
    while ((t == 0 || ((t - 1) % FR) / SD != 2) && guard < 2 * FR) begin
      @(negedge clk);
      guard++;
    end
    chk("align_digit2", an, 4'b1011);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_an", an, 4'b1111);
    chk("midrst_ft", frame_tick, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ft", frame_tick, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_dwell", {an, frame_tick}, {4'b1110, 1'b0});
    end
    @(negedge clk);
    chk("post_rst_d1", an, 4'b1101);

    // Randomized soak with occasional alarm toggles and resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0: cnt0 = 4'($urandom_range(0, 15));
          1: cnt1 = 4'($urandom_range(0, 15));
          2: cnt2 = 4'($urandom_range(0, 15));
          default: cnt3 = 4'($urandom_range(0, 15));
        endcase
      end
      if ($urandom_range(0, 149) == 0) led_on = ~led_on;
      rst = ($urandom_range(0, 399) == 0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
